// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mips_pkg
// Description : Shared types and constants for the 16-bit MIPS instruction
//               memory boot loader. Provides the loader state encoding,
//               instruction/data width constants and a checksum helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int INSTR_BYTES = 2;   // bytes per instruction word
  localparam int DATA_W      = 16;  // instruction word width
  localparam int BYTE_W      = 8;   // stream byte width

  // Loader FSM states, 3-bit encoding.
  typedef enum logic [2:0] {
    LEN_HI  = 3'd0,
    LEN_LO  = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    CSUM    = 3'd4,
    RUN     = 3'd5,
    ERR     = 3'd6
  } loader_state_t;

  // 8-bit running checksum; wraps mod 256.
  function automatic logic [BYTE_W-1:0] csum_add(input logic [BYTE_W-1:0] acc,
                                                  input logic [BYTE_W-1:0] b);
    return acc + b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/boot_byte_assembler.sv
`default_nettype none
// ============================================================================
// Module      : boot_byte_assembler
// Description : Pairs a hi byte and a lo byte into a 16-bit instruction word
//               and issues a registered, one-cycle instruction-memory write.
// Ports       : clk, rst_n      - clock, synchronous active-low reset
//               hi_load         - accepted byte is the word's hi byte
//               lo_load         - accepted byte is the word's lo byte
//               byte_in         - accepted byte
//               word_idx        - index of the word being completed
//               imem_we/addr/wdata - instruction memory write port
// Revision    : 1.0 - initial release
// ============================================================================
module boot_byte_assembler
  import mips_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hi_load,
  input  logic              lo_load,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic [15:0]       word_idx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata
);

  logic [BYTE_W-1:0] hi_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= lo_load;
      if (hi_load) begin
        hi_q <= byte_in;
      end
      if (lo_load) begin
        imem_wdata <= {hi_q, byte_in};
        // Byte address of the word; the cast wraps it at ADDR_W bits.
        imem_addr  <= ADDR_W'(32'(word_idx) * INSTR_BYTES);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_boot_loader
// Description : Receives a big-endian program image (16-bit length N, 2N
//               payload bytes, 8-bit checksum) over a valid/ready byte stream,
//               writes it into instruction memory and releases the core only
//               when the checksum matches.
// Ports       : clk, rst_n            - clock, synchronous active-low reset
//               in_valid/in_data/in_ready - byte stream handshake
//               start                 - restart loading from RUN or ERR
//               imem_we/addr/wdata    - instruction memory write port
//               core_run              - pipeline release level
//               load_done/load_error  - image accepted / rejected
//               words_loaded          - words written in the current load
// Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_loader
  import mips_pkg::*;
#(
  parameter int MAX_WORDS = 512,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              core_run,
  output logic              load_done,
  output logic              load_error,
  output logic [15:0]       words_loaded
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

  loader_state_t state_q, state_d;
  logic [15:0]   len_q;
  logic [7:0]    csum_q;
  logic [15:0]   word_idx_q;

  logic          accept;
  logic [15:0]   len_full;
  logic          len_ok;
  logic          last_word;
  logic          restart;

  // in_ready is forced low while reset is asserted.
  assign in_ready  = rst_n && (state_q != RUN) && (state_q != ERR);
  assign accept    = in_valid && in_ready;
  assign len_full  = {len_q[15:8], in_data};
  assign len_ok    = (len_full != 16'd0) && (len_full <= MAX_LEN);
  // len_q <= MAX_WORDS, so index+1 cannot overflow 16 bits.
  assign last_word = (word_idx_q + 16'd1) == len_q;
  assign restart   = start && ((state_q == RUN) || (state_q == ERR));

  assign words_loaded = word_idx_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      LEN_HI:  if (accept) state_d = LEN_LO;
      LEN_LO:  if (accept) state_d = len_ok ? DATA_HI : ERR;
      DATA_HI: if (accept) state_d = DATA_LO;
      DATA_LO: if (accept) state_d = last_word ? CSUM : DATA_HI;
      CSUM:    if (accept) state_d = (in_data == csum_q) ? RUN : ERR;
      RUN,
      ERR:     if (start) state_d = LEN_HI;
      default: state_d = LEN_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= LEN_HI;
      len_q      <= '0;
      csum_q     <= '0;
      word_idx_q <= '0;
      core_run   <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        case (state_q)
          LEN_HI: len_q[15:8] <= in_data;
          LEN_LO: begin
            len_q[7:0] <= in_data;
            csum_q     <= '0;
            word_idx_q <= '0;
            if (!len_ok) load_error <= 1'b1;
          end
          DATA_HI: csum_q <= csum_add(csum_q, in_data);
          DATA_LO: begin
            csum_q     <= csum_add(csum_q, in_data);
            // Advances together with the registered write strobe.
            word_idx_q <= word_idx_q + 16'd1;
          end
          CSUM: begin
            if (in_data == csum_q) begin
              core_run  <= 1'b1;
              load_done <= 1'b1;
            end else begin
              load_error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (restart) begin
        core_run   <= 1'b0;
        load_done  <= 1'b0;
        load_error <= 1'b0;
        word_idx_q <= '0;
      end
    end
  end

  boot_byte_assembler #(
    .ADDR_W (ADDR_W)
  ) u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .hi_load    (accept && (state_q == DATA_HI)),
    .lo_load    (accept && (state_q == DATA_LO)),
    .byte_in    (in_data),
    .word_idx   (word_idx_q),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_boot_loader
// Description : Self-checking bench for imem_boot_loader. Table of images
//               with expected end results, a write scoreboard fed while bytes
//               are driven, and hand sequences for restart and reset corners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

  localparam int MAX_WORDS = 512;
  localparam int ADDR_W    = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              start = 1'b0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              core_run;
  logic              load_done;
  logic              load_error;
  logic [15:0]       words_loaded;

  imem_boot_loader #(
    .MAX_WORDS (MAX_WORDS),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .start        (start),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_run     (core_run),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] words;
  } wr_t;

  typedef struct {
    string       name;
    bit          do_reset;
    logic [63:0] img;
    int          nbytes;
    bit          gaps;
    bit          exp_run;
    bit          exp_err;
    logic [15:0] exp_words;
  } case_t;

  wr_t   exp_q[$];
  case_t cases[6];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every write strobe must match the oldest expected write.
  always begin : mon
    wr_t e;
    @(posedge clk);
    #1;
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h expected no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(imem_addr), 32'(e.addr));
        chk("wr_data", 32'(imem_wdata), 32'(e.data));
        chk("wr_words_loaded", 32'(words_loaded), 32'(e.words));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps, output bit ok);
    ok = 1'b0;
    if (gaps) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(1, 0) == 0) break;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
    end
    for (int t = 0; t < 16 && !ok; t++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
  endtask

  // Drives an image and pushes each expected write as its lo byte is driven.
  task automatic send_image(input logic [63:0] img, input int n, input bit gaps);
    logic [7:0]  b;
    logic [7:0]  hi;
    logic [15:0] len;
    bit          ok;
    int          p;
    hi  = 8'h00;
    len = 16'h0000;
    for (int i = 0; i < n; i++) begin
      b = img[63-8*i -: 8];
      if (i == 0) len[15:8] = b;
      else if (i == 1) len[7:0] = b;
      else begin
        p = i - 2;
        if (len != 16'd0 && int'(len) <= MAX_WORDS && p < 2 * int'(len)) begin
          if (p % 2 == 0) hi = b;
          else exp_q.push_back('{addr: 16'(p - 1), data: {hi, b}, words: 16'((p + 1) / 2)});
        end
      end
      send_byte(b, gaps, ok);
      chk("byte_accepted", 32'(ok), 32'd1);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_imem_wdata", 32'(imem_wdata), 32'd0);
    chk("rst_core_run", 32'(core_run), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_load_error", 32'(load_error), 32'd0);
    chk("rst_words_loaded", 32'(words_loaded), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_core_run", 32'(core_run), 32'd0);
    chk("start_load_done", 32'(load_done), 32'd0);
    chk("start_load_error", 32'(load_error), 32'd0);
    chk("start_words_loaded", 32'(words_loaded), 32'd0);
    chk("start_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic check_result(input string name, input bit run, input bit err, input logic [15:0] words);
    chk({name, "_core_run"}, 32'(core_run), 32'(run));
    chk({name, "_load_done"}, 32'(load_done), 32'(run));
    chk({name, "_load_error"}, 32'(load_error), 32'(err));
    chk({name, "_words_loaded"}, 32'(words_loaded), 32'(words));
    chk({name, "_in_ready"}, 32'(in_ready), 32'((run || err) ? 0 : 1));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit ok;
    cases[0] = '{"basic",   1'b1, 64'h0002_1234_ABCD_BE00, 7, 1'b0, 1'b1, 1'b0, 16'd2};
    cases[1] = '{"badcsum", 1'b0, 64'h0002_1234_ABCD_BF00, 7, 1'b0, 1'b0, 1'b1, 16'd2};
    cases[2] = '{"len0",    1'b0, 64'h0000_0000_0000_0000, 2, 1'b0, 1'b0, 1'b1, 16'd0};
    cases[3] = '{"lenmax1", 1'b0, 64'h0201_0000_0000_0000, 2, 1'b0, 1'b0, 1'b1, 16'd0};
    cases[4] = '{"gaps",    1'b0, 64'h0002_1234_ABCD_BE00, 7, 1'b1, 1'b1, 1'b0, 16'd2};
    cases[5] = '{"wrap",    1'b0, 64'h0001_FFFF_FE00_0000, 5, 1'b0, 1'b1, 1'b0, 16'd1};

    for (int c = 0; c < 6; c++) begin
      if (cases[c].do_reset) apply_reset();
      else pulse_start();
      send_image(cases[c].img, cases[c].nbytes, cases[c].gaps);
      check_result(cases[c].name, cases[c].exp_run, cases[c].exp_err, cases[c].exp_words);
      // Valid held high in RUN/ERR must not move anything.
      repeat (3) @(negedge clk);
      #1;
      chk({cases[c].name, "_hold_words"}, 32'(words_loaded), 32'(cases[c].exp_words));
      chk({cases[c].name, "_hold_run"}, 32'(core_run), 32'(cases[c].exp_run));
      chk({cases[c].name, "_writes_seen"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      in_valid = 1'b0;
    end

    // start while loading is ignored: 1-word image 12 34, checksum 46.
    pulse_start();
    send_image(64'h0001_0000_0000_0000, 2, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("ignored_start_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back('{addr: 16'h0000, data: 16'h1234, words: 16'd1});
    send_byte(8'h12, 1'b0, ok);
    chk("ign_b0", 32'(ok), 32'd1);
    send_byte(8'h34, 1'b0, ok);
    chk("ign_b1", 32'(ok), 32'd1);
    send_byte(8'h46, 1'b0, ok);
    chk("ign_b2", 32'(ok), 32'd1);
    check_result("ignored_start", 1'b1, 1'b0, 16'd1);
    chk("ignored_start_writes_seen", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // Reset after the first payload word, then a fresh 1-word image.
    pulse_start();
    send_image(64'h0002_1234_0000_0000, 4, 1'b0);
    chk("midload_core_run", 32'(core_run), 32'd0);
    apply_reset();
    chk("midload_writes_seen", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    send_image(64'h0001_0007_0700_0000, 5, 1'b0);
    check_result("after_reset", 1'b1, 1'b0, 16'd1);
    chk("after_reset_writes_seen", 32'(exp_q.size()), 32'd0);
    in_valid = 1'b0;

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
